// File: rtl/spi_register_master_pkg.sv
// Shared constants, state encoding and frame helper for the SPI register master.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spi_register_master_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_READ_BIT   = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Analyzer register map
  localparam logic [6:0] REG_ACQ_CTRL = 7'h00;  // bit0 acquisition enable, bit1 acquisition reset
  localparam logic [6:0] REG_CLK_SEL  = 7'h01;  // sample clock source select
  localparam logic [6:0] REG_CLK_DIV  = 7'h02;  // sample clock divisor
  localparam logic [6:0] REG_CH_EN    = 7'h03;  // channel enable mask

  // Wire frame: read flag, 7-bit address, data byte (zero for reads)
  function automatic logic [SPI_FRAME_BITS-1:0] spi_build_frame(
    input logic       rd,
    input logic [6:0] addr,
    input logic [7:0] wdata
  );
    return {rd, addr, (rd ? 8'h00 : wdata)};
  endfunction

endpackage

// File: rtl/spi_register_master_synchronizer.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops so a metastable first stage has a full cycle to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_register_master.sv
// SPI mode-0 master issuing one 16-bit register read/write frame per accepted command.
// Latency: rsp_valid 1+34*HALF cycles after acceptance; ready again at 1+35*HALF.
// Backpressure: cmd_ready stays low for the whole frame; a held cmd_valid waits, never drops.
module spi_register_master
  import spi_register_master_pkg::*;
#(
  parameter int HALF = 4  // sclk half-period in clk cycles, legal 4..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

  spi_state_t                  state;
  logic [7:0]                  half_cnt;
  logic [3:0]                  bit_cnt;
  // Bits still to be sent after the one currently on mosi
  logic [SPI_FRAME_BITS-2:0]   tx_shift;
  // Only the data-phase byte is kept; command-phase miso bits shift out the top
  logic [7:0]                  rx_shift;
  logic [SPI_FRAME_BITS-1:0]   frame;
  logic                        miso_sync;
  logic                        half_done;

  assign half_done = (half_cnt == HALF_LAST);

  // Frame as it would be latched if the current command were accepted this cycle
  always_comb begin
    frame = spi_build_frame(cmd_read, cmd_addr, cmd_wdata);
  end

  synchronizer #(.WIDTH(1)) u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d   (miso),
    .q   (miso_sync)
  );

  // Transaction FSM; every output is registered and set on the transition into its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ss        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tx_shift  <= frame[SPI_FRAME_BITS-2:0];
            mosi      <= frame[SPI_READ_BIT];
            ss        <= 1'b0;
            sclk      <= 1'b0;
            cmd_ready <= 1'b0;
            half_cnt  <= '0;
            bit_cnt   <= 4'(SPI_FRAME_BITS - 1);
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (half_done) begin
            half_cnt <= '0;
            state    <= ST_SHIFT;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (!half_done) begin
            half_cnt <= half_cnt + 8'd1;
          end else begin
            half_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // End of the high phase: sample, then fall and present the next bit
              sclk     <= 1'b0;
              rx_shift <= {rx_shift[6:0], miso_sync};
              if (bit_cnt == 4'd0) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt  <= bit_cnt - 4'd1;
                mosi     <= tx_shift[SPI_FRAME_BITS-2];
                tx_shift <= {tx_shift[SPI_FRAME_BITS-3:0], 1'b0};
              end
            end
          end
        end

        ST_HOLD: begin
          if (half_done) begin
            half_cnt  <= '0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_shift;
            state     <= ST_GAP;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        ST_GAP: begin
          if (half_done) begin
            half_cnt  <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          ss        <= 1'b1;
          sclk      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_register_master.sv
// Directed bench for spi_register_master with an SPI slave model and response/frame scoreboards.
// Two instances: HALF=4 with an immediate slave, HALF=7 with miso delayed 3 cycles.
// Expected frames and read data come from the bench's own shadow register file.
module tb_spi_register_master;
  import spi_register_master_pkg::*;

  localparam int HALF_A = 4;
  localparam int HALF_B = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic       rst_a, cmd_valid_a, cmd_ready_a, cmd_read_a, rsp_valid_a;
  logic [6:0] cmd_addr_a;
  logic [7:0] cmd_wdata_a, rsp_rdata_a;
  logic       ss_a, sclk_a, mosi_a, miso_a;

  logic       rst_b, cmd_valid_b, cmd_ready_b, cmd_read_b, rsp_valid_b;
  logic [6:0] cmd_addr_b;
  logic [7:0] cmd_wdata_b, rsp_rdata_b;
  logic       ss_b, sclk_b, mosi_b, miso_b;

  spi_register_master #(.HALF(HALF_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_read(cmd_read_a), .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .ss(ss_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_register_master #(.HALF(HALF_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_read(cmd_read_b), .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .ss(ss_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
  );

  typedef struct {
    logic [7:0] rdata;
    int         acc;
  } rsp_exp_t;

  rsp_exp_t   rsp_q_a[$];
  rsp_exp_t   rsp_q_b[$];
  logic [15:0] frame_q_a[$];
  logic [15:0] frame_q_b[$];
  logic [7:0] shadow_a[128];
  logic [7:0] shadow_b[128];
  logic [7:0] mem_a[128];
  logic [7:0] mem_b[128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model A (miso changes right at the sclk fall) ----------------
  int          a_cnt = 0;
  logic [15:0] a_rx = '0;
  logic [7:0]  a_tx = '0;
  bit          a_active = 1'b0;
  bit          abort_a = 1'b0;

  always @(negedge ss_a) begin
    a_active = 1'b1;
    a_cnt = 0;
    a_rx = '0;
    a_tx = '0;
  end

  always @(posedge sclk_a) begin
    if (a_active) begin
      a_rx = {a_rx[14:0], mosi_a};
      a_cnt++;
      if (a_cnt == 8) a_tx = a_rx[7] ? mem_a[a_rx[6:0]] : 8'h00;
    end
  end

  always @(negedge sclk_a) begin
    miso_a = (a_active && a_cnt >= 8 && a_cnt < 16) ? a_tx[3'(15 - a_cnt)] : 1'b0;
  end

  always @(posedge ss_a) begin
    if (a_active) begin
      a_active = 1'b0;
      if (abort_a) begin
        abort_a = 1'b0;
      end else begin
        check("a_frame_present", frame_q_a.size() != 0, 1);
        if (frame_q_a.size() != 0) begin
          logic [15:0] e;
          e = frame_q_a.pop_front();
          check("a_frame", a_rx, e);
        end
        check("a_sclk_rises", a_cnt, 16);
        if (a_cnt == 16 && !a_rx[15]) mem_a[a_rx[14:8]] = a_rx[7:0];
      end
    end
  end

  // ---------------- slave model B (miso changes 3 clk cycles after the sclk fall) ----------------
  int          b_cnt = 0;
  logic [15:0] b_rx = '0;
  logic [7:0]  b_tx = '0;
  bit          b_active = 1'b0;

  always @(negedge ss_b) begin
    b_active = 1'b1;
    b_cnt = 0;
    b_rx = '0;
    b_tx = '0;
  end

  always @(posedge sclk_b) begin
    if (b_active) begin
      b_rx = {b_rx[14:0], mosi_b};
      b_cnt++;
      if (b_cnt == 8) b_tx = b_rx[7] ? mem_b[b_rx[6:0]] : 8'h00;
    end
  end

  always @(negedge sclk_b) begin
    logic v;
    v = (b_active && b_cnt >= 8 && b_cnt < 16) ? b_tx[3'(15 - b_cnt)] : 1'b0;
    repeat (3) @(posedge clk);
    miso_b = v;
  end

  always @(posedge ss_b) begin
    if (b_active) begin
      b_active = 1'b0;
      check("b_frame_present", frame_q_b.size() != 0, 1);
      if (frame_q_b.size() != 0) begin
        logic [15:0] e;
        e = frame_q_b.pop_front();
        check("b_frame", b_rx, e);
      end
      check("b_sclk_rises", b_cnt, 16);
    end
  end

  // ---------------- response monitors ----------------
  always @(negedge clk) begin
    if (rsp_valid_a) begin
      check("a_rsp_expected", rsp_q_a.size() != 0, 1);
      check("a_rsp_ready_excl", cmd_ready_a, 0);
      if (rsp_q_a.size() != 0) begin
        rsp_exp_t ex;
        ex = rsp_q_a.pop_front();
        check("a_rsp_rdata", rsp_rdata_a, ex.rdata);
        check("a_rsp_latency", cyc - ex.acc, 1 + 34 * HALF_A);
      end
    end
    if (rsp_valid_b) begin
      check("b_rsp_expected", rsp_q_b.size() != 0, 1);
      check("b_rsp_ready_excl", cmd_ready_b, 0);
      if (rsp_q_b.size() != 0) begin
        rsp_exp_t ex;
        ex = rsp_q_b.pop_front();
        check("b_rsp_rdata", rsp_rdata_b, ex.rdata);
        check("b_rsp_latency", cyc - ex.acc, 1 + 34 * HALF_B);
      end
    end
  end

  // ss high time between frames on instance A
  int a_hi_run = 0;
  bit a_seen = 1'b0;
  always @(negedge clk) begin
    if (ss_a === 1'b1) begin
      a_hi_run++;
    end else if (ss_a === 1'b0) begin
      if (a_seen && a_hi_run > 0) begin
        checks++;
        assert (a_hi_run >= HALF_A) else begin
          errors++;
          $error("FAIL a_ss_gap: observed %0d cycles expected >= %0d", a_hi_run, HALF_A);
        end
      end
      a_hi_run = 0;
      a_seen = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_a(input logic rd, input logic [6:0] addr, input logic [7:0] wd,
                        input bit expect_rsp, output int acc);
    logic [7:0] exp_rd;
    cmd_valid_a = 1'b1;
    cmd_read_a  = rd;
    cmd_addr_a  = addr;
    cmd_wdata_a = wd;
    acc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_ready_a) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("a_accept", acc >= 0, 1);
    if (expect_rsp) begin
      frame_q_a.push_back({rd, addr, (rd ? 8'h00 : wd)});
      exp_rd = rd ? shadow_a[addr] : 8'h00;
      rsp_q_a.push_back('{exp_rd, acc});
      if (!rd) shadow_a[addr] = wd;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle_a();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready_a && !a_active && rsp_q_a.size() == 0 && frame_q_a.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_idle", ok, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  acc;
    int  acc_b;
    bit  found;

    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 8'h00;
      shadow_a[i] = 8'h00;
      mem_b[i] = 8'h00;
      shadow_b[i] = 8'h00;
    end
    mem_a[REG_CLK_SEL] = 8'hC3;
    shadow_a[REG_CLK_SEL] = 8'hC3;
    mem_b[REG_CH_EN] = 8'hA5;
    shadow_b[REG_CH_EN] = 8'hA5;

    rst_a = 1'b1;
    rst_b = 1'b1;
    cmd_valid_a = 1'b0; cmd_read_a = 1'b0; cmd_addr_a = '0; cmd_wdata_a = '0;
    cmd_valid_b = 1'b0; cmd_read_b = 1'b0; cmd_addr_b = '0; cmd_wdata_b = '0;
    miso_a = 1'b0;
    miso_b = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready_a, 1);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_rsp_rdata", rsp_rdata_a, 8'h00);
    check("rst_ss", ss_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_b_ss", ss_b, 1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write 0x5A to channel-enable register, timing of ss fall and first sclk rise
    send_a(1'b0, REG_CH_EN, 8'h5A, 1'b1, acc);
    cmd_valid_a = 1'b0;
    check("t1_ss_fall", ss_a, 0);
    check("t1_ss_fall_cycle", cyc - acc, 1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sclk_a) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t1_sclk_seen", found, 1);
    check("t1_first_rise", cyc - acc, 1 + 2 * HALF_A);
    wait_idle_a();

    // 2: read clock-select register, slave returns 0xC3; data held after the pulse
    send_a(1'b1, REG_CLK_SEL, 8'hEE, 1'b1, acc);
    cmd_valid_a = 1'b0;
    wait_idle_a();
    repeat (5) @(negedge clk);
    check("t2_rdata_held", rsp_rdata_a, 8'hC3);

    // 3: cmd_valid held across two commands: write 0x11 then read it back
    send_a(1'b0, REG_CLK_DIV, 8'h11, 1'b1, acc);
    check("t3_ready_low", cmd_ready_a, 0);
    send_a(1'b1, REG_CLK_DIV, 8'h00, 1'b1, acc);
    cmd_valid_a = 1'b0;
    wait_idle_a();
    check("t3_rdata", rsp_rdata_a, 8'h11);

    // 4: inputs scrambled right after acceptance must not reach the wire
    send_a(1'b0, 7'h06, 8'h22, 1'b1, acc);
    cmd_valid_a = 1'b0;
    cmd_read_a  = 1'b1;
    cmd_addr_a  = 7'h7F;
    cmd_wdata_a = 8'hFF;
    wait_idle_a();

    // 5: reset during bit 7 of the shift phase, then a full frame must follow
    abort_a = 1'b1;
    send_a(1'b0, 7'h05, 8'h7E, 1'b0, acc);
    cmd_valid_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a_cnt == 9 && sclk_a) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t5_bit7_seen", found, 1);
    rst_a = 1'b1;
    #1;
    check("t5_rst_ss", ss_a, 1);
    check("t5_rst_sclk", sclk_a, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rsp_valid", rsp_valid_a, 0);
    check("t5_rsp_rdata", rsp_rdata_a, 8'h00);
    check("t5_abort_cleared", abort_a, 0);
    send_a(1'b0, 7'h05, 8'h3C, 1'b1, acc);
    cmd_valid_a = 1'b0;
    wait_idle_a();
    send_a(1'b1, 7'h05, 8'h00, 1'b1, acc);
    cmd_valid_a = 1'b0;
    wait_idle_a();
    check("t5_readback", rsp_rdata_a, 8'h3C);

    // 6: HALF=7 instance, slave drives miso 3 cycles late
    cmd_read_b  = 1'b1;
    cmd_addr_b  = REG_CH_EN;
    cmd_wdata_b = 8'hFF;
    cmd_valid_b = 1'b1;
    acc_b = -1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready_b) begin
        acc_b = cyc;
        break;
      end
      @(negedge clk);
    end
    check("b_accept", acc_b >= 0, 1);
    frame_q_b.push_back({1'b1, REG_CH_EN, 8'h00});
    rsp_q_b.push_back('{shadow_b[REG_CH_EN], acc_b});
    @(negedge clk);
    cmd_valid_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready_b && !b_active && rsp_q_b.size() == 0 && frame_q_b.size() == 0) begin
        found = 1'b1;
        break;
      end
    end
    check("b_idle", found, 1);
    check("b_rdata", rsp_rdata_b, 8'hA5);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
